// File: rtl/mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types and constants for the system RAM arbiter.
//   mem_owner_e        : who owns the read data returning next cycle
//   RAM_UNMAPPED_*     : hole in the CPU address map (0x280..0xDFF)
//   VRAM_BASE          : start of the display region scanned by the LCD reader
//   addr_is_unmapped() : true when a 12-bit address falls in the hole
// ----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_CPU  = 2'd1,
        OWNER_DISP = 2'd2
    } mem_owner_e;

    localparam logic [11:0] RAM_UNMAPPED_START = 12'h280;
    localparam logic [11:0] RAM_UNMAPPED_END   = 12'hDFF;
    localparam logic [11:0] VRAM_BASE          = 12'hE00;

    function automatic logic addr_is_unmapped(input logic [11:0] addr);
        return (addr >= RAM_UNMAPPED_START) && (addr <= RAM_UNMAPPED_END);
    endfunction

endpackage

// File: rtl/mem_arb_starve_counter.sv
// ----------------------------------------------------------------------------
// mem_arb_starve_counter
// Counts consecutive cycles a display request has been refused. Saturates at
// STARVE_LIMIT; clears on a display grant or when the display stops asking.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   disp_req      : display read request
//   disp_ready    : display granted this cycle
//   force_grant   : display has waited STARVE_LIMIT cycles and must win now
// ----------------------------------------------------------------------------
module mem_arb_starve_counter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic disp_req,
    input  logic disp_ready,
    output logic force_grant
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (!disp_req || disp_ready) begin
            count_d = 4'd0;
        end else if (count_q != LIMIT) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Uses the registered count, so the force decision never loops back
    // through disp_ready within the same cycle.
    assign force_grant = disp_req && (count_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Shares the single-port 4-bit system RAM (synchronous read, 1-cycle latency)
// between the CPU memory path and the LCD scan-out reader. The CPU has fixed
// priority; a starvation counter forces a display grant after STARVE_LIMIT
// refused cycles.
//
// Ports:
//   clk, reset_n                       : clock, asynchronous active-low reset
//   cpu_req/cpu_write_en/cpu_addr/
//   cpu_write_data                     : CPU access request
//   cpu_ready                          : CPU access accepted this cycle
//   cpu_read_valid/cpu_read_data       : CPU read return (1 cycle after grant)
//   disp_req/disp_addr                 : display read request
//   disp_ready                         : display access accepted this cycle
//   disp_read_valid/disp_read_data     : display read return
//   mem_addr/mem_write_en/
//   mem_write_data/mem_read_data       : RAM interface
//   starve_active                      : forced display grant this cycle
//   range_err (MEM_ARB_RANGE_CHECK_EN) : CPU access to the unmapped hole
//
// Build option MEM_ARB_RANGE_CHECK_EN: CPU accesses to 0x280..0xDFF are
// accepted but never written, reads of them return 0, and range_err pulses
// on acceptance. Without it every address goes straight to the RAM.
// ----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned DATA_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpu_req,
    input  logic                  cpu_write_en,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_write_data,
    output logic                  cpu_ready,
    output logic                  cpu_read_valid,
    output logic [DATA_WIDTH-1:0] cpu_read_data,
    input  logic                  disp_req,
    input  logic [ADDR_WIDTH-1:0] disp_addr,
    output logic                  disp_ready,
    output logic                  disp_read_valid,
    output logic [DATA_WIDTH-1:0] disp_read_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_write_en,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  starve_active
`ifdef MEM_ARB_RANGE_CHECK_EN
    ,
    output logic                  range_err
`endif
);

    logic                  force_grant;
    logic                  cpu_xfer;
    logic                  disp_xfer;
    logic                  cpu_unmapped;
    logic                  rd_blank;
    logic [ADDR_WIDTH-1:0] addr_q;
    mem_owner_e            rd_owner_q;
    mem_owner_e            rd_owner_d;

    mem_arb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk         (clk),
        .reset_n     (reset_n),
        .disp_req    (disp_req),
        .disp_ready  (disp_ready),
        .force_grant (force_grant)
    );

    // Arbitration: CPU first unless the display has starved long enough.
    assign cpu_ready     = cpu_req && !force_grant;
    assign disp_ready    = disp_req && (force_grant || !cpu_req);
    assign starve_active = force_grant;
    assign cpu_xfer      = cpu_req && cpu_ready;
    assign disp_xfer     = disp_req && disp_ready;

`ifdef MEM_ARB_RANGE_CHECK_EN
    logic rd_blank_q;

    assign cpu_unmapped = addr_is_unmapped(12'(cpu_addr));
    assign range_err    = cpu_xfer && cpu_unmapped;
    assign rd_blank     = rd_blank_q;

    // Marks a CPU read of the unmapped hole so its return data is zeroed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_blank_q <= 1'b0;
        end else begin
            rd_blank_q <= cpu_xfer && !cpu_write_en && cpu_unmapped;
        end
    end
`else
    assign cpu_unmapped = 1'b0;
    assign rd_blank     = 1'b0;
`endif

    // RAM side. The address holds its last granted value when idle so the RAM
    // sees no spurious toggling. The write strobe is gated by reset so a
    // request held during reset cannot corrupt memory.
    assign mem_addr       = cpu_xfer  ? cpu_addr  :
                            disp_xfer ? disp_addr : addr_q;
    assign mem_write_en   = reset_n && cpu_xfer && cpu_write_en && !cpu_unmapped;
    assign mem_write_data = cpu_write_data;

    always_comb begin
        rd_owner_d = OWNER_NONE;
        if (cpu_xfer && !cpu_write_en) begin
            rd_owner_d = OWNER_CPU;
        end else if (disp_xfer) begin
            rd_owner_d = OWNER_DISP;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= '0;
            rd_owner_q <= OWNER_NONE;
        end else begin
            addr_q     <= mem_addr;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Read return: only the owner sees RAM data; the other side reads zero.
    assign cpu_read_valid  = (rd_owner_q == OWNER_CPU);
    assign disp_read_valid = (rd_owner_q == OWNER_DISP);
    assign cpu_read_data   = (cpu_read_valid && !rd_blank) ? mem_read_data : '0;
    assign disp_read_data  = disp_read_valid ? mem_read_data : '0;

endmodule
